// File: rtl/fetch_pkg.sv
// Shared types and constants for the MIPS instruction-fetch stage.
package fetch_pkg;

    localparam logic [31:0] NOP                = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_HALT_INSTR = 32'hFFFF_FFFF;
    localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_ADDR_LIMIT = 32'h0000_1000;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pcPlus4;
        logic        valid;
    } ifid_t;

    localparam ifid_t IFID_BUBBLE = '{instr: NOP, pcPlus4: 32'h0, valid: 1'b0};

    function automatic logic [31:0] alignWord(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_pc_next_logic.sv
// Combinational next-PC selection and halt detection for the fetch stage.
module pc_next_logic
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter logic [31:0] ADDR_LIMIT = DEFAULT_ADDR_LIMIT,
    parameter logic [31:0] HALT_INSTR = DEFAULT_HALT_INSTR
) (
    input  logic        reset_i,
    input  logic        halted_i,
    input  logic        redirect_i,
    input  logic [31:0] redirectTarget_i,
    input  logic        stall_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] imemInstruction_i,
    output logic [31:0] pcNext_o,
    output logic [31:0] pcPlus4_o,
    output logic        haltFire_o,
    output logic        fetchFire_o
);

    logic haltCond;

    assign pcPlus4_o = pc_i + 32'd4;
    assign haltCond  = (imemInstruction_i == HALT_INSTR) || (pc_i >= ADDR_LIMIT);

    // Priority: reset, halted freeze, redirect, stall, halt check, sequential fetch.
    always_comb begin
        pcNext_o    = pc_i;
        haltFire_o  = 1'b0;
        fetchFire_o = 1'b0;
        if (reset_i) begin
            pcNext_o = alignWord(RESET_PC);
        end else if (halted_i) begin
            pcNext_o = pc_i;
        end else if (redirect_i) begin
            pcNext_o = alignWord(redirectTarget_i);
        end else if (stall_i) begin
            pcNext_o = pc_i;
        end else if (haltCond) begin
            haltFire_o = 1'b1;
        end else begin
            pcNext_o    = pcPlus4_o;
            fetchFire_o = 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register, run/halt FSM and fetch counter.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter logic [31:0] ADDR_LIMIT = DEFAULT_ADDR_LIMIT,
    parameter logic [31:0] HALT_INSTR = DEFAULT_HALT_INSTR
) (
    input  logic        Clk_i,
    input  logic        Reset_i,
    input  logic        Stall_i,
    input  logic        Redirect_i,
    input  logic [31:0] RedirectTarget_i,
    output logic [31:0] ImemAddress_o,
    input  logic [31:0] ImemInstruction_i,
    output logic [31:0] IfIdInstruction_o,
    output logic [31:0] IfIdPCPlus4_o,
    output logic        IfIdValid_o,
    output logic        Halted_o,
    output logic [31:0] FetchCount_o
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    ifid_t        ifid_q, ifid_d;
    logic [31:0]  fetchCount_q, fetchCount_d;
    logic [31:0]  pcPlus4;
    logic         haltFire;
    logic         fetchFire;
    logic         isHalted;

    assign isHalted = (state_q == HALTED);

    pc_next_logic #(
        .RESET_PC   (RESET_PC),
        .ADDR_LIMIT (ADDR_LIMIT),
        .HALT_INSTR (HALT_INSTR)
    ) u_pc_next (
        .reset_i           (Reset_i),
        .halted_i          (isHalted),
        .redirect_i        (Redirect_i),
        .redirectTarget_i  (RedirectTarget_i),
        .stall_i           (Stall_i),
        .pc_i              (pc_q),
        .imemInstruction_i (ImemInstruction_i),
        .pcNext_o          (pc_d),
        .pcPlus4_o         (pcPlus4),
        .haltFire_o        (haltFire),
        .fetchFire_o       (fetchFire)
    );

    always_ff @(posedge Clk_i) begin
        if (Reset_i) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (haltFire) state_d = HALTED;
            HALTED:  state_d = HALTED;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        Halted_o = isHalted;
    end

    // A stalled, non-redirected RUN cycle is the only case where IF/ID keeps its contents.
    always_comb begin
        ifid_d       = IFID_BUBBLE;
        fetchCount_d = fetchCount_q;
        if (fetchFire) begin
            ifid_d.instr   = ImemInstruction_i;
            ifid_d.pcPlus4 = pcPlus4;
            ifid_d.valid   = 1'b1;
            fetchCount_d   = fetchCount_q + 32'd1;
        end else if (!isHalted && !Redirect_i && Stall_i) begin
            ifid_d = ifid_q;
        end
    end

    always_ff @(posedge Clk_i) begin
        if (Reset_i) begin
            pc_q         <= alignWord(RESET_PC);
            ifid_q       <= IFID_BUBBLE;
            fetchCount_q <= 32'd0;
        end else begin
            pc_q         <= pc_d;
            ifid_q       <= ifid_d;
            fetchCount_q <= fetchCount_d;
        end
    end

    assign ImemAddress_o     = pc_q;
    assign IfIdInstruction_o = ifid_q.instr;
    assign IfIdPCPlus4_o     = ifid_q.pcPlus4;
    assign IfIdValid_o       = ifid_q.valid;
    assign FetchCount_o      = fetchCount_q;

endmodule
